// File: rtl/pdm_stream_iom.sv
// IO-bus peripheral that buffers duty samples in a FIFO and releases one per
// programmable sample period to a downstream pdm modulator.
module pdm_stream_iom #(
  parameter int DUTY_BITS = 8,
  parameter int FIFO_AW   = 4,
  parameter int DIV_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 io_addr_strobe,
  input  logic                 io_read_strobe,
  input  logic                 io_write_strobe,
  input  logic [11:0]          io_address,
  input  logic [3:0]           io_byte_enable,
  input  logic [31:0]          io_write_data,
  output logic [31:0]          io_read_data,
  output logic                 io_ready,
  output logic [DUTY_BITS-1:0] duty,
  output logic                 pdm_en,
  output logic                 sample_tick,
  output logic                 irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);

  logic [DUTY_BITS-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wptr, r_rptr;
  logic [FIFO_AW:0]     r_level;
  logic [DIV_BITS-1:0]  r_div, r_cnt;
  logic [DUTY_BITS-1:0] r_duty;
  logic                 r_en, r_irq_en, r_und, r_ovf, r_irq, r_ready;
  logic [31:0]          r_rdata;

  logic w_wr, w_rd, w_sel_ctrl, w_sel_status, w_sel_div, w_sel_data;
  logic w_flush, w_empty, w_full, w_tick;
  logic w_push_req, w_push, w_pop_req, w_pop;
  logic w_und_nxt, w_ovf_nxt, w_irq_en_nxt;
  logic [7:0]  w_lvl8;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_wr         = io_addr_strobe & io_write_strobe;
  assign w_rd         = io_addr_strobe & io_read_strobe;
  assign w_sel_ctrl   = (io_address == 12'h000);
  assign w_sel_status = (io_address == 12'h004);
  assign w_sel_div    = (io_address == 12'h008);
  assign w_sel_data   = (io_address == 12'h00C);
  assign w_flush      = w_wr & w_sel_ctrl & io_write_data[1];
  assign w_empty      = (r_level == '0);
  assign w_full       = (r_level == LVL_FULL);
  assign w_tick       = r_en & (r_cnt == r_div);

  // Full/empty are judged on the pre-edge level: no bypass into an empty FIFO.
  assign w_push_req = w_wr & w_sel_data & ~w_flush;
  assign w_push     = w_push_req & ~w_full;
  assign w_pop_req  = w_tick & ~w_flush;
  assign w_pop      = w_pop_req & ~w_empty;

  assign w_lvl8   = 8'(r_level);
  assign w_unused = ^{io_byte_enable, io_write_data};

  // Setting a sticky flag wins over a same-cycle clear.
  always_comb begin
    w_und_nxt    = r_und;
    w_ovf_nxt    = r_ovf;
    w_irq_en_nxt = r_irq_en;
    if (w_wr && w_sel_status && io_write_data[2]) w_und_nxt = 1'b0;
    if (w_wr && w_sel_status && io_write_data[3]) w_ovf_nxt = 1'b0;
    if (w_pop_req && w_empty)                     w_und_nxt = 1'b1;
    if (w_push_req && w_full)                     w_ovf_nxt = 1'b1;
    if (w_wr && w_sel_ctrl)                       w_irq_en_nxt = io_write_data[2];
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_ctrl)   w_rdata = {29'd0, r_irq_en, 1'b0, r_en};
    if (w_sel_status) w_rdata = {16'd0, w_lvl8, 4'd0, r_ovf, r_und, w_full, w_empty};
    if (w_sel_div)    w_rdata = 32'(r_div);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= io_write_data[DUTY_BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_duty   <= '0;
      r_und    <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ready  <= io_addr_strobe;
      r_rdata  <= w_rd ? w_rdata : 32'd0;
      r_und    <= w_und_nxt;
      r_ovf    <= w_ovf_nxt;
      r_irq_en <= w_irq_en_nxt;
      r_irq    <= w_irq_en_nxt & (w_und_nxt | w_ovf_nxt);
      if (w_wr && w_sel_ctrl) r_en  <= io_write_data[0];
      if (w_wr && w_sel_div)  r_div <= io_write_data[DIV_BITS-1:0];

      // A counter above a newly lowered DIV simply wraps through the top.
      if (w_flush || !r_en)   r_cnt <= '0;
      else if (w_tick)        r_cnt <= '0;
      else                    r_cnt <= r_cnt + DIV_BITS'(1);

      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
        if (w_pop) begin
          r_rptr <= r_rptr + FIFO_AW'(1);
          r_duty <= r_mem[r_rptr];
        end
        if (w_push && !w_pop)      r_level <= r_level + (FIFO_AW+1)'(1);
        else if (!w_push && w_pop) r_level <= r_level - (FIFO_AW+1)'(1);
      end
    end
  end

  assign io_ready     = r_ready;
  assign io_read_data = r_rdata;
  assign duty         = r_duty;
  assign pdm_en       = r_en;
  assign sample_tick  = w_tick;
  assign irq          = r_irq;
endmodule

// File: tb/tb_pdm_stream_iom.sv
// Directed bench for pdm_stream_iom: register map, sample pacing, FIFO
// full/empty handling, streaming at DIV=0, interrupt and async reset.
module tb_pdm_stream_iom;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_addr_strobe = 1'b0;
  logic        io_read_strobe = 1'b0;
  logic        io_write_strobe = 1'b0;
  logic [11:0] io_address = '0;
  logic [3:0]  io_byte_enable = 4'hF;
  logic [31:0] io_write_data = '0;
  logic [31:0] io_read_data;
  logic        io_ready;
  logic [7:0]  duty;
  logic        pdm_en, sample_tick, irq;

  int n_checks = 0;
  int n_fail   = 0;

  pdm_stream_iom dut (
    .clk(clk), .rst(rst),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_address(io_address),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready),
    .duty(duty), .pdm_en(pdm_en), .sample_tick(sample_tick), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    io_addr_strobe = 1'b1; io_write_strobe = 1'b1; io_address = a; io_write_data = d;
    @(negedge clk);
    io_addr_strobe = 1'b0; io_write_strobe = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic rdy);
    @(negedge clk);
    io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_address = a;
    @(negedge clk);
    d = io_read_data; rdy = io_ready;
    io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        rdy;
    logic [11:0] addrs [4] = '{12'h000, 12'h004, 12'h008, 12'h010};
    logic [31:0] exps  [4] = '{32'h0, 32'h1, 32'h0, 32'h0};
    repeat (3) @(negedge clk);
    n_checks++; if ({duty, pdm_en, sample_tick, irq, io_ready} !== 12'd0) begin
      n_fail++; $display("FAIL reset_outputs: got duty=%0h en=%0b tick=%0b irq=%0b rdy=%0b exp all 0",
                         duty, pdm_en, sample_tick, irq, io_ready); end
    n_checks++; if (io_read_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %0h exp 0", io_read_data); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], d, rdy);
      n_checks++; if (d !== exps[i]) begin
        n_fail++; $display("FAIL reset_read_%0h: got %0h exp %0h", addrs[i], d, exps[i]); end
      n_checks++; if (rdy !== 1'b1) begin
        n_fail++; $display("FAIL reset_ready_%0h: got %0b exp 1", addrs[i], rdy); end
    end
    @(negedge clk);
    n_checks++; if (io_ready !== 1'b0 || io_read_data !== 32'd0) begin
      n_fail++; $display("FAIL ready_pulse_width: got rdy=%0b data=%0h exp 0/0", io_ready, io_read_data); end
  endtask

  task automatic test_paced_stream();
    logic [31:0] d;
    logic        rdy;
    logic [7:0]  exp_duty;
    bus_write(12'h008, 32'd3);
    bus_write(12'h00C, 32'h10);
    bus_write(12'h00C, 32'h20);
    bus_write(12'h00C, 32'h30);
    bus_write(12'h000, 32'h1);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      exp_duty = (k <= 4) ? 8'h00 : (k <= 8) ? 8'h10 : (k <= 12) ? 8'h20 : 8'h30;
      n_checks++; if (sample_tick !== ((k % 4) == 0)) begin
        n_fail++; $display("FAIL pace_tick_c%0d: got %0b exp %0b", k, sample_tick, (k % 4) == 0); end
      n_checks++; if (duty !== exp_duty) begin
        n_fail++; $display("FAIL pace_duty_c%0d: got %0h exp %0h", k, duty, exp_duty); end
    end
    @(negedge clk);
    n_checks++; if (duty !== 8'h30) begin
      n_fail++; $display("FAIL pace_hold_after_underrun: got %0h exp 30", duty); end
    bus_write(12'h000, 32'h0);
    bus_read(12'h004, d, rdy);
    n_checks++; if (d !== 32'h0000_0005) begin
      n_fail++; $display("FAIL pace_underrun_status: got %0h exp 5", d); end
  endtask

  task automatic test_overflow_flush();
    logic [31:0] d;
    logic        rdy;
    bus_write(12'h004, 32'hC);
    for (int i = 0; i < 17; i++) bus_write(12'h00C, 32'(i));
    bus_read(12'h004, d, rdy);
    n_checks++; if (d !== 32'h0000_100A) begin
      n_fail++; $display("FAIL full_status: got %0h exp 100a", d); end
    bus_write(12'h004, 32'h8);
    bus_read(12'h004, d, rdy);
    n_checks++; if (d !== 32'h0000_1002) begin
      n_fail++; $display("FAIL overflow_clear: got %0h exp 1002", d); end
    bus_write(12'h000, 32'h2);
    bus_read(12'h004, d, rdy);
    n_checks++; if (d !== 32'h0000_0001) begin
      n_fail++; $display("FAIL flush_status: got %0h exp 1", d); end
    bus_read(12'h000, d, rdy);
    n_checks++; if (d !== 32'h0) begin
      n_fail++; $display("FAIL flush_ctrl_readback: got %0h exp 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        rdy;
    logic [7:0]  exp_duty;
    for (int i = 0; i < 8; i++) bus_write(12'h00C, 32'h40 + 32'(i));
    bus_write(12'h008, 32'd0);
    @(negedge clk);
    io_addr_strobe = 1'b1; io_write_strobe = 1'b1; io_address = 12'h000; io_write_data = 32'h1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      n_checks++; if (io_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready_c%0d: got %0b exp 1", k, io_ready); end
      if (k >= 2) begin
        exp_duty = 8'h40 + 8'(k - 2);
        n_checks++; if (duty !== exp_duty) begin
          n_fail++; $display("FAIL b2b_duty_c%0d: got %0h exp %0h", k, duty, exp_duty); end
      end
      if (k <= 16) begin
        io_address = 12'h00C; io_write_data = 32'h48 + 32'(k - 1);
      end else begin
        io_address = 12'h000; io_write_data = 32'h0;
      end
    end
    @(negedge clk);
    io_addr_strobe = 1'b0; io_write_strobe = 1'b0;
    n_checks++; if (duty !== 8'h50) begin
      n_fail++; $display("FAIL b2b_last_duty: got %0h exp 50", duty); end
    bus_read(12'h004, d, rdy);
    n_checks++; if (d !== 32'h0000_0700) begin
      n_fail++; $display("FAIL b2b_status: got %0h exp 700", d); end
  endtask

  task automatic test_irq_and_reset();
    logic [31:0] d;
    logic        rdy;
    bus_write(12'h000, 32'h2);
    bus_write(12'h004, 32'hC);
    bus_write(12'h008, 32'd1);
    bus_write(12'h000, 32'h5);
    n_checks++; if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_idle: got %0b exp 0", irq); end
    @(negedge clk);
    n_checks++; if (sample_tick !== 1'b1 || irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_tick_cycle: got tick=%0b irq=%0b exp 1/0", sample_tick, irq); end
    @(negedge clk);
    n_checks++; if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_raise: got %0b exp 1", irq); end
    bus_write(12'h000, 32'h4);
    n_checks++; if (irq !== 1'b1 || pdm_en !== 1'b0) begin
      n_fail++; $display("FAIL irq_hold: got irq=%0b en=%0b exp 1/0", irq, pdm_en); end
    bus_write(12'h004, 32'h4);
    n_checks++; if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: got %0b exp 0", irq); end
    bus_read(12'h004, d, rdy);
    n_checks++; if (d !== 32'h1) begin
      n_fail++; $display("FAIL irq_clear_status: got %0h exp 1", d); end

    bus_write(12'h00C, 32'h77);
    bus_write(12'h008, 32'd0);
    bus_write(12'h000, 32'h5);
    repeat (2) @(negedge clk);
    n_checks++; if (duty !== 8'h77 || irq !== 1'b1 || pdm_en !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got duty=%0h irq=%0b en=%0b exp 77/1/1", duty, irq, pdm_en); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({duty, pdm_en, sample_tick, irq, io_ready} !== 12'd0 || io_read_data !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: got duty=%0h en=%0b tick=%0b irq=%0b rdy=%0b data=%0h exp all 0",
                         duty, pdm_en, sample_tick, irq, io_ready, io_read_data); end
    @(negedge clk);
    rst = 1'b0;
    bus_read(12'h004, d, rdy);
    n_checks++; if (d !== 32'h1) begin
      n_fail++; $display("FAIL post_reset_status: got %0h exp 1", d); end
    bus_read(12'h000, d, rdy);
    n_checks++; if (d !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_ctrl: got %0h exp 0", d); end
  endtask

  initial begin
    test_reset();
    test_paced_stream();
    test_overflow_flush();
    test_back_to_back();
    test_irq_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
